// File: rtl/psum_accumulator.sv
// psum_accumulator: streaming signed partial-sum accumulator with shift, optional rounding and saturation.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input handshake; in_data signed partial sum, in_last ends the vector
//   cfg_shift              right-shift amount, sampled on the first beat of each vector
//   out_valid/out_ready    output handshake; out_data signed activation, out_sat set when clipped
// Define PSUM_ACC_ROUND_EN for round-half-up before the shift; otherwise results truncate toward -inf.
module psum_accumulator #(
   parameter int IN_WIDTH    = 32,
   parameter int ACC_WIDTH   = 40,
   parameter int OUT_WIDTH   = 16,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_WIDTH-1:0]    in_data,
   input  logic                   in_last,
   input  logic [SHIFT_WIDTH-1:0] cfg_shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_sat
);
   typedef enum logic {ACC, HOLD} state_t;
   localparam logic signed [ACC_WIDTH:0] SAT_MAX = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
   state_t                        state_q;
   logic                          first_q, out_valid_q, out_sat_q, sat_hi, sat_lo;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [SHIFT_WIDTH-1:0]        shift_q, shift_d;
   logic signed [ACC_WIDTH:0]     ext, rnd, shd;
   logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
   assign in_ready  = state_q == ACC;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   // Post-processing runs one bit wider than the accumulator so the rounding add cannot overflow.
   always_comb begin
      acc_d   = (first_q ? '0 : acc_q) + ACC_WIDTH'($signed(in_data));
      shift_d = first_q ? cfg_shift : shift_q;
      ext     = {acc_d[ACC_WIDTH-1], acc_d};
`ifdef PSUM_ACC_ROUND_EN
      rnd     = ext + ((shift_d != '0) ? ((ACC_WIDTH+1)'(1) << (shift_d - SHIFT_WIDTH'(1))) : '0);
`else
      rnd     = ext;
`endif
      shd        = rnd >>> shift_d;
      sat_hi     = shd > SAT_MAX;
      sat_lo     = shd < SAT_MIN;
      out_data_d = sat_hi ? SAT_MAX[OUT_WIDTH-1:0] : sat_lo ? SAT_MIN[OUT_WIDTH-1:0] : shd[OUT_WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         first_q     <= 1'b1;
         acc_q       <= '0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else if (state_q == ACC) begin
         if (in_valid) begin
            if (first_q) shift_q <= cfg_shift;
            if (in_last) begin
               out_data_q  <= out_data_d;
               out_sat_q   <= sat_hi | sat_lo;
               out_valid_q <= 1'b1;
               first_q     <= 1'b1;
               state_q     <= HOLD;
            end else begin
               acc_q   <= acc_d;
               first_q <= 1'b0;
            end
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
         state_q     <= ACC;
      end
   end
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed and randomized checks of psum_accumulator against an arithmetic reference model.
module tb_psum_accumulator;
   localparam int IW = 32, AW = 40, OW = 16, SW = 5;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [IW-1:0] in_data = '0;
   logic [SW-1:0] cfg_shift = '0;
   logic in_ready, out_valid, out_sat;
   logic [OW-1:0] out_data;
   int tests = 0, fails = 0;
   longint beats[$];

   psum_accumulator dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .cfg_shift(cfg_shift), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: exact integer sum wrapped to the accumulator width, optional +half, floor division, clamp.
   function automatic void model(input int sh, output longint d, output longint s);
      longint v = 0, den, q, hi, lo;
      foreach (beats[i]) v += beats[i];
      v = v & ((64'sd1 << AW) - 1);
      if (v >= (64'sd1 << (AW - 1))) v -= (64'sd1 << AW);
`ifdef PSUM_ACC_ROUND_EN
      if (sh > 0) v += 64'sd1 << (sh - 1);
`endif
      den = 64'sd1 << sh;
      q = v / den;
      if (v % den != 0 && v < 0) q--;
      hi = (64'sd1 << (OW - 1)) - 1;
      lo = -(64'sd1 << (OW - 1));
      s = (q > hi || q < lo) ? 1 : 0;
      d = q > hi ? hi : q < lo ? lo : q;
   endfunction

   task automatic run_vec(input int sh, input bit chg, input int gaps, input int stall, input bit early, input string tag);
      longint ed, es;
      logic [OW-1:0] held;
      model(sh, ed, es);
      out_ready = early;
      foreach (beats[i]) begin
         repeat ($urandom_range(0, gaps)) begin
            in_valid = 1'b0; in_last = 1'($urandom); in_data = IW'($urandom); cfg_shift = SW'($urandom);
            @(posedge clk); #1;
         end
         chk({tag, "_in_ready"}, in_ready, 1);
         in_valid  = 1'b1;
         in_data   = beats[i][IW-1:0];
         in_last   = (i == beats.size() - 1);
         cfg_shift = (i == 0 || !chg) ? SW'(sh) : SW'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_out_data"}, $signed(out_data), ed);
      chk({tag, "_out_sat"}, out_sat, es);
      chk({tag, "_hold_ready"}, in_ready, 0);
      held = out_data;
      if (!early) repeat (stall) begin
         @(posedge clk); #1;
         chk({tag, "_stall_valid"}, out_valid, 1);
         chk({tag, "_stall_data"}, out_data, held);
         chk({tag, "_stall_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_done_valid"}, out_valid, 0);
      chk({tag, "_done_ready"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      beats = '{100};                          run_vec(0, 0, 0, 0, 0, "single");
      beats = '{10, 20, -3};                   run_vec(2, 0, 0, 0, 0, "three");
      beats = '{64'sh7FFFFFFF, 64'sh7FFFFFFF}; run_vec(0, 0, 0, 0, 0, "sat_hi");
      beats = '{-40000};                       run_vec(0, 0, 0, 0, 0, "sat_lo");
      beats = '{-5};                           run_vec(1, 0, 0, 0, 0, "neg_round");
      beats = '{10, 20, -3};                   run_vec(2, 1, 0, 0, 0, "shift_change");
      beats = '{1234, -77};                    run_vec(3, 0, 0, 5, 0, "backpressure");
      beats = '{-9, 4, 300};                   run_vec(1, 0, 2, 0, 1, "early_ready");

      in_valid = 1'b1; in_last = 1'b0; in_data = 50; cfg_shift = '0;
      @(posedge clk); #1;
      in_data = 60;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_mid_valid", out_valid, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_after", out_valid, 0);
      beats = '{7}; run_vec(0, 0, 0, 0, 0, "rst_mid_new");

      in_valid = 1'b1; in_last = 1'b1; in_data = 55; cfg_shift = '0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      chk("rst_hold_pending", out_valid, 1);
      rst_n = 1'b0;
      #2;
      chk("rst_hold_valid", out_valid, 0);
      chk("rst_hold_data", out_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      beats = '{-3, 8}; run_vec(0, 0, 0, 0, 0, "rst_hold_new");

      for (int n = 0; n < 40; n++) begin
         int len, sh, big;
         bit early;
         beats.delete();
         len = $urandom_range(1, 8);
         big = $urandom_range(0, 1);
         for (int k = 0; k < len; k++)
            beats.push_back(big ? longint'($signed(IW'($urandom))) : longint'($urandom_range(0, 200000)) - 100000);
         sh = $urandom_range(0, 31);
         early = 1'($urandom);
         run_vec(sh, 1'($urandom), 2, $urandom_range(0, 3), early, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
